// File: rtl/bcd_code_recognizer.sv
// Multi-digit BCD code recognizer: captures one digit per enter press, compares against CODE.
// Optional idle abort in COLLECT is built only when BCR_TIMEOUT_EN is defined.
module bcd_code_recognizer #(
  parameter int unsigned               NUM_DIGITS     = 2,
  parameter logic [4*NUM_DIGITS-1:0]   CODE           = 8'h45,
  parameter int unsigned               TIMEOUT_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [3:0]              digit_in,
  input  logic                    enter,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [2:0]              count_out,
  output logic                    match,
  output logic                    match_pulse,
  output logic                    error
);

  localparam int unsigned BufW    = 4 * NUM_DIGITS;
  localparam logic [2:0]  LastCnt = 3'(NUM_DIGITS);

  typedef enum logic [1:0] {StIdle, StCollect, StMatch, StFail} state_e;

  if (NUM_DIGITS < 1 || NUM_DIGITS > 6 || TIMEOUT_CYCLES == 0) begin : g_bad_param
    $error("bcd_code_recognizer: NUM_DIGITS must be 1..6 and TIMEOUT_CYCLES nonzero");
  end

  state_e            r_state, w_state_d;
  logic [BufW-1:0]   r_buf, w_buf_d, w_first;
  logic [2:0]        r_cnt, w_cnt_d;
  logic              r_enter_q, r_match, r_error, r_pulse;
  logic              w_match_d, w_error_d, w_pulse_d, w_hit;
  logic              w_press, w_valid, w_timeout;

  assign w_press = enter & ~r_enter_q;
  assign w_valid = (digit_in <= 4'd9);

`ifdef BCR_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] r_tmo;

  // Counts idle cycles in COLLECT; any press or leaving COLLECT restarts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tmo <= '0;
    end else if (w_state_d != StCollect || w_press) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + 1'b1;
    end
  end

  assign w_timeout = (r_state == StCollect) && (r_tmo == TmoW'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= StIdle;
      r_buf     <= '0;
      r_cnt     <= '0;
      r_enter_q <= 1'b0;
      r_match   <= 1'b0;
      r_error   <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_buf     <= w_buf_d;
      r_cnt     <= w_cnt_d;
      r_enter_q <= enter;
      r_match   <= w_match_d;
      r_error   <= w_error_d;
      r_pulse   <= w_pulse_d;
    end
  end

  // Next-state logic; compare sees the buffer including this cycle's digit.
  always_comb begin
    w_state_d   = r_state;
    w_buf_d     = r_buf;
    w_cnt_d     = r_cnt;
    w_hit       = 1'b0;
    w_first     = '0;
    w_first[3:0] = digit_in;
    if (clear) begin
      w_state_d = StIdle;
      w_buf_d   = '0;
      w_cnt_d   = '0;
    end else if (w_press) begin
      if (!w_valid) begin
        w_state_d = StFail;
      end else begin
        if (r_state == StCollect) begin
          w_buf_d = (r_buf << 4) | w_first;
          w_cnt_d = r_cnt + 3'd1;
        end else begin
          // IDLE, MATCH and FAIL all start a fresh sequence
          w_buf_d = w_first;
          w_cnt_d = 3'd1;
        end
        if (w_cnt_d == LastCnt) begin
          w_hit     = (w_buf_d == CODE);
          w_state_d = w_hit ? StMatch : StFail;
        end else begin
          w_state_d = StCollect;
        end
      end
    end else if (w_timeout) begin
      w_state_d = StIdle;
      w_buf_d   = '0;
      w_cnt_d   = '0;
    end
  end

  // Output logic, registered alongside the state
  always_comb begin
    w_match_d = (w_state_d == StMatch);
    w_error_d = (w_state_d == StFail);
    w_pulse_d = w_hit;
  end

  assign digits_out  = r_buf;
  assign count_out   = r_cnt;
  assign match       = r_match;
  assign match_pulse = r_pulse;
  assign error       = r_error;

endmodule

// File: tb/tb_bcd_code_recognizer.sv
// Directed bench for bcd_code_recognizer (NUM_DIGITS=2, CODE=8'h45).
// The idle-abort checks are compiled in only when BCR_TIMEOUT_EN is defined.
module tb_bcd_code_recognizer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] digit_in;
  logic       enter;
  logic       clear;
  logic [7:0] digits_out;
  logic [2:0] count_out;
  logic       match;
  logic       match_pulse;
  logic       error;

  int n_chk = 0;
  int n_err = 0;

  bcd_code_recognizer #(
    .NUM_DIGITS    (2),
    .CODE          (8'h45),
    .TIMEOUT_CYCLES(1000)
  ) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .digit_in   (digit_in),
    .enter      (enter),
    .clear      (clear),
    .digits_out (digits_out),
    .count_out  (count_out),
    .match      (match),
    .match_pulse(match_pulse),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] dig, input logic [2:0] cnt,
                           input logic m, input logic mp, input logic e);
    check_eq({tag, ".digits"}, 32'(digits_out), 32'(dig));
    check_eq({tag, ".count"},  32'(count_out),  32'(cnt));
    check_eq({tag, ".match"},  32'(match),      32'(m));
    check_eq({tag, ".pulse"},  32'(match_pulse), 32'(mp));
    check_eq({tag, ".error"},  32'(error),      32'(e));
  endtask

  // One-cycle press; returns on the negedge after the capturing posedge.
  task automatic press(input logic [3:0] d);
    @(negedge clk);
    digit_in = d;
    enter    = 1'b1;
    @(negedge clk);
    enter    = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    reset_n  = 1'b0;
    digit_in = 4'd0;
    enter    = 1'b0;
    clear    = 1'b0;
    #3;
    check_out("reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Correct code 4,5
    press(4'd4);
    check_out("t1.first", 8'h04, 3'd1, 1'b0, 1'b0, 1'b0);
    press(4'd5);
    check_out("t1.match", 8'h45, 3'd2, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check_out("t1.hold", 8'h45, 3'd2, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("t1.sat_count", 32'(count_out), 32'd2);

    // Wrong code 4,6 then a fresh sequence
    press(4'd4);
    check_out("t2.newseq", 8'h04, 3'd1, 1'b0, 1'b0, 1'b0);
    press(4'd6);
    check_out("t2.fail", 8'h46, 3'd2, 1'b0, 1'b0, 1'b1);
    press(4'd4);
    check_out("t2.restart", 8'h04, 3'd1, 1'b0, 1'b0, 1'b0);

    // Held enter captures once
    do_clear();
    check_out("t3.clear", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    digit_in = 4'd4;
    enter    = 1'b1;
    repeat (20) @(negedge clk);
    check_out("t3.held", 8'h04, 3'd1, 1'b0, 1'b0, 1'b0);
    enter = 1'b0;
    press(4'd5);
    check_out("t3.after", 8'h45, 3'd2, 1'b1, 1'b1, 1'b0);

    // Invalid digit from IDLE, then recovery
    do_clear();
    press(4'hA);
    check_out("t4.inv_idle", 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
    press(4'd4);
    check_out("t4.recover", 8'h04, 3'd1, 1'b0, 1'b0, 1'b0);
    // Invalid digit mid-sequence keeps buffer and count
    press(4'hB);
    check_out("t4.inv_coll", 8'h04, 3'd1, 1'b0, 1'b0, 1'b1);

    // clear beats a simultaneous completing press
    do_clear();
    press(4'd4);
    @(negedge clk);
    digit_in = 4'd5;
    enter    = 1'b1;
    clear    = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    clear = 1'b0;
    check_out("t5.clear_win", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t5.no_match", 32'(match), 32'd0);
    end

    // Asynchronous reset mid-sequence
    press(4'd4);
    check_eq("t5.pre_rst_count", 32'(count_out), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_out("t5.async_rst", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

`ifdef BCR_TIMEOUT_EN
    press(4'd4);
    repeat (999) @(negedge clk);
    check_eq("t6.before_tmo", 32'(count_out), 32'd1);
    @(negedge clk);
    check_out("t6.timeout", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    press(4'd4);
    repeat (998) @(negedge clk);
    press(4'd5);
    check_out("t6.press_wins", 8'h45, 3'd2, 1'b1, 1'b1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
